axi_txn_scheduler: RTL and testbench

AXI_TXN_SCHEDULER -- requirements
Module: axi_txn_scheduler

---
 rtl/axi_txn_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/axi_txn_scheduler.sv | 152 +++++++++++++++
 tb/tb_axi_txn_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_txn_pkg.sv
// Shared types and constants for the AXI transaction scheduler.
// Holds the FSM state encoding and the burst-length limits.
package axi_txn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RSP    = 2'd3
  } state_t;

  localparam int MAX_BURST_LEN = 256;
  localparam int LEN_WIDTH     = 9;

  // A burst is launchable only when it moves at least one and at most MAX_BURST_LEN beats.
  function automatic logic len_ok(input logic [LEN_WIDTH-1:0] len);
    return (len != '0) && (len <= LEN_WIDTH'(MAX_BURST_LEN));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the requester after the last grant
// and returns the first active request as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found                          = 1'b1;
        grant[(int'(last) + k) % N]    = 1'b1;
        grant_idx                      = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/axi_txn_scheduler.sv
// Arbitrates burst requests from several requesters onto one AXI master,
// launches each accepted burst, and reports completion, AXI error or timeout.
module axi_txn_scheduler
  import axi_txn_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic [NUM_REQ-1:0]            REQ_OP,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  REQ_LEN,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic                          RSP_ERROR,
  output logic                          INIT_AXI_TXN,
  output logic                          OP_TYPE,
  output logic [ADDR_WIDTH-1:0]         BASE_ADDR,
  output logic [LEN_WIDTH-1:0]          BURST_LEN,
  input  logic                          AXI_TXN_DONE,
  input  logic                          AXI_ERROR,
  output logic                          BUSY,
  output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_next;

  logic [IW-1:0]         last_ptr;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  sel_op;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  accept;
  logic                  timeout;
  logic [CW-1:0]         wait_cnt;
  logic [NUM_REQ-1:0]    grant_onehot;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req       (REQ_VALID),
    .last      (last_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Fields of the winning requester, picked by the one-hot grant.
  always_comb begin
    sel_op   = 1'b0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_op   = REQ_OP[i];
        sel_addr = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = REQ_LEN[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT_ID == IW'(i)) grant_onehot[i] = 1'b1;
    end
  end

  assign timeout = (wait_cnt >= CW'(TIMEOUT_CYCLES - 1));
  assign BUSY    = (state != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and the combinational accept strobe; DONE is only looked at in WAIT.
  always_comb begin
    state_next = state;
    REQ_READY  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!ARESET && (|REQ_VALID)) begin
          accept     = 1'b1;
          REQ_READY  = arb_grant;
          state_next = len_ok(sel_len) ? LAUNCH : RSP;
        end
      end
      LAUNCH:  state_next = WAIT;
      WAIT:    if (AXI_TXN_DONE || timeout) state_next = RSP;
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction registers; the response is registered on the edge that enters RSP.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_ptr     <= IW'(NUM_REQ - 1);
      GRANT_ID     <= '0;
      OP_TYPE      <= 1'b0;
      BASE_ADDR    <= '0;
      BURST_LEN    <= '0;
      INIT_AXI_TXN <= 1'b0;
      RSP_VALID    <= '0;
      RSP_ERROR    <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      INIT_AXI_TXN <= 1'b0;
      RSP_VALID    <= '0;
      RSP_ERROR    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            GRANT_ID  <= arb_idx;
            OP_TYPE   <= sel_op;
            BASE_ADDR <= sel_addr;
            BURST_LEN <= sel_len;
            if (len_ok(sel_len)) begin
              INIT_AXI_TXN <= 1'b1;
            end else begin
              RSP_VALID <= arb_grant;
              RSP_ERROR <= 1'b1;
            end
          end
        end
        LAUNCH: wait_cnt <= '0;
        WAIT: begin
          if (AXI_TXN_DONE) begin
            RSP_VALID <= grant_onehot;
            RSP_ERROR <= AXI_ERROR;
          end else if (timeout) begin
            RSP_VALID <= grant_onehot;
            RSP_ERROR <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RSP:     last_ptr <= GRANT_ID;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed bench for axi_txn_scheduler with four requesters and a 16-cycle timeout.
module tb_axi_txn_scheduler;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [3:0]   REQ_VALID, REQ_READY, REQ_OP, RSP_VALID;
  logic [127:0] REQ_ADDR;
  logic [35:0]  REQ_LEN;
  logic         RSP_ERROR, INIT_AXI_TXN, OP_TYPE;
  logic [31:0]  BASE_ADDR;
  logic [8:0]   BURST_LEN;
  logic         AXI_TXN_DONE, AXI_ERROR, BUSY;
  logic [1:0]   GRANT_ID;

  int total = 0;
  int bad   = 0;

  axi_txn_scheduler #(
    .NUM_REQ(4),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .RSP_VALID(RSP_VALID), .RSP_ERROR(RSP_ERROR), .INIT_AXI_TXN(INIT_AXI_TXN),
    .OP_TYPE(OP_TYPE), .BASE_ADDR(BASE_ADDR), .BURST_LEN(BURST_LEN),
    .AXI_TXN_DONE(AXI_TXN_DONE), .AXI_ERROR(AXI_ERROR),
    .BUSY(BUSY), .GRANT_ID(GRANT_ID)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog got=hang want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic op, input logic [31:0] addr, input logic [8:0] len);
    REQ_VALID[i]         = 1'b1;
    REQ_OP[i]            = op;
    REQ_ADDR[i*32 +: 32] = addr;
    REQ_LEN[i*9 +: 9]    = len;
  endtask

  task automatic do_reset();
    ARESET       = 1'b1;
    REQ_VALID    = '0;
    AXI_TXN_DONE = 1'b0;
    AXI_ERROR    = 1'b0;
    step();
    step();
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; REQ_VALID = 4'b1111; REQ_OP = '0; REQ_ADDR = '0; REQ_LEN = '0;
    AXI_TXN_DONE = 1'b0; AXI_ERROR = 1'b0;
    step(); step();
    total++; if (REQ_READY !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0000", REQ_READY); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", BUSY); end
    total++; if ({INIT_AXI_TXN, RSP_VALID, RSP_ERROR} !== 6'b0) begin bad++; $display("[TB] FAIL reset_pulses got=%b want=000000", {INIT_AXI_TXN, RSP_VALID, RSP_ERROR}); end
    total++; if ({OP_TYPE, BASE_ADDR, BURST_LEN, GRANT_ID} !== 44'h0) begin bad++; $display("[TB] FAIL reset_fields got=%h want=0", {OP_TYPE, BASE_ADDR, BURST_LEN, GRANT_ID}); end
    REQ_VALID = '0;
    ARESET    = 1'b0;
    step();
  endtask

  task automatic test_single();
    int early;
    early = 0;
    set_req(0, 1'b0, 32'h8000_0000, 9'd1);
    #1;
    total++; if (REQ_READY !== 4'b0001) begin bad++; $display("[TB] FAIL single_ready got=%b want=0001", REQ_READY); end
    step();
    REQ_VALID = '0;
    total++; if (INIT_AXI_TXN !== 1'b1) begin bad++; $display("[TB] FAIL single_init got=%b want=1", INIT_AXI_TXN); end
    total++; if (BURST_LEN !== 9'd1) begin bad++; $display("[TB] FAIL single_len got=%0d want=1", BURST_LEN); end
    total++; if (BASE_ADDR !== 32'h8000_0000 || OP_TYPE !== 1'b0 || GRANT_ID !== 2'd0) begin bad++; $display("[TB] FAIL single_fields got=%h/%b/%0d want=80000000/0/0", BASE_ADDR, OP_TYPE, GRANT_ID); end
    step();
    total++; if (INIT_AXI_TXN !== 1'b0 || BUSY !== 1'b1) begin bad++; $display("[TB] FAIL single_init_pulse got=%b/%b want=0/1", INIT_AXI_TXN, BUSY); end
    for (int k = 1; k <= 9; k++) begin
      step();
      if (RSP_VALID !== 4'b0000 || INIT_AXI_TXN !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("[TB] FAIL single_wait got=%0d want=0 early pulses", early); end
    AXI_TXN_DONE = 1'b1;
    step();
    AXI_TXN_DONE = 1'b0;
    total++; if (RSP_VALID !== 4'b0001 || RSP_ERROR !== 1'b0) begin bad++; $display("[TB] FAIL single_rsp got=%b/%b want=0001/0", RSP_VALID, RSP_ERROR); end
    step();
    total++; if (RSP_VALID !== 4'b0000 || BUSY !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%b/%b want=0000/0", RSP_VALID, BUSY); end
  endtask

  task automatic test_contention();
    int exp_id;
    logic [3:0] exp_oh;
    int grants [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      grants[i] = 0;
      set_req(i, logic'(i % 2), 32'h1000 * (i + 1), 9'(i + 1));
    end
    for (int k = 0; k < 8; k++) begin
      exp_id = k % 4;
      exp_oh = 4'b0001 << exp_id;
      #1;
      total++; if (REQ_READY !== exp_oh) begin bad++; $display("[TB] FAIL rr_ready%0d got=%b want=%b", k, REQ_READY, exp_oh); end
      step();
      if (GRANT_ID <= 2'd3) grants[GRANT_ID]++;
      total++; if (GRANT_ID !== 2'(exp_id) || BASE_ADDR !== 32'h1000 * (exp_id + 1) || BURST_LEN !== 9'(exp_id + 1)) begin
        bad++; $display("[TB] FAIL rr_grant%0d got=%0d/%h/%0d want=%0d/%h/%0d", k, GRANT_ID, BASE_ADDR, BURST_LEN, exp_id, 32'h1000 * (exp_id + 1), exp_id + 1);
      end
      total++; if (REQ_READY !== 4'b0000 || INIT_AXI_TXN !== 1'b1) begin bad++; $display("[TB] FAIL rr_launch%0d got=%b/%b want=0000/1", k, REQ_READY, INIT_AXI_TXN); end
      step();
      AXI_TXN_DONE = 1'b1;
      step();
      AXI_TXN_DONE = 1'b0;
      total++; if (RSP_VALID !== exp_oh) begin bad++; $display("[TB] FAIL rr_rsp%0d got=%b want=%b", k, RSP_VALID, exp_oh); end
      step();
    end
    REQ_VALID = '0;
    total++; if (grants[0] != 2 || grants[1] != 2 || grants[2] != 2 || grants[3] != 2) begin
      bad++; $display("[TB] FAIL rr_fairness got=%0d,%0d,%0d,%0d want=2,2,2,2", grants[0], grants[1], grants[2], grants[3]);
    end
  endtask

  task automatic test_bad_len();
    logic [8:0] lens [2];
    lens[0] = 9'd0;
    lens[1] = 9'd257;
    for (int j = 0; j < 2; j++) begin
      set_req(2, 1'b0, 32'h2000, lens[j]);
      #1;
      total++; if (REQ_READY !== 4'b0100) begin bad++; $display("[TB] FAIL badlen_ready%0d got=%b want=0100", j, REQ_READY); end
      step();
      REQ_VALID = '0;
      total++; if (RSP_VALID !== 4'b0100 || RSP_ERROR !== 1'b1 || INIT_AXI_TXN !== 1'b0) begin
        bad++; $display("[TB] FAIL badlen_rsp%0d got=%b/%b/%b want=0100/1/0", j, RSP_VALID, RSP_ERROR, INIT_AXI_TXN);
      end
      step();
      total++; if (INIT_AXI_TXN !== 1'b0 || RSP_VALID !== 4'b0000 || BUSY !== 1'b0) begin
        bad++; $display("[TB] FAIL badlen_idle%0d got=%b/%b/%b want=0/0000/0", j, INIT_AXI_TXN, RSP_VALID, BUSY);
      end
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    set_req(1, 1'b0, 32'h3000, 9'd16);
    step();
    REQ_VALID = '0;
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      if (RSP_VALID !== 4'b0000) early++;
    end
    total++; if (early != 0 || BUSY !== 1'b1) begin bad++; $display("[TB] FAIL timeout_early got=%0d/%b want=0/1", early, BUSY); end
    step();
    total++; if (RSP_VALID !== 4'b0010 || RSP_ERROR !== 1'b1) begin bad++; $display("[TB] FAIL timeout_rsp got=%b/%b want=0010/1", RSP_VALID, RSP_ERROR); end
    step();
  endtask

  task automatic test_same_cycle();
    set_req(3, 1'b1, 32'h4000, 9'd8);
    step();
    REQ_VALID = '0;
    step();
    for (int k = 1; k <= 15; k++) step();
    AXI_TXN_DONE = 1'b1;
    AXI_ERROR    = 1'b0;
    step();
    AXI_TXN_DONE = 1'b0;
    total++; if (RSP_VALID !== 4'b1000 || RSP_ERROR !== 1'b0) begin bad++; $display("[TB] FAIL done_vs_timeout got=%b/%b want=1000/0", RSP_VALID, RSP_ERROR); end
    step();
  endtask

  task automatic test_axi_error();
    set_req(0, 1'b1, 32'hDEAD_BEEC, 9'd256);
    #1;
    total++; if (REQ_READY !== 4'b0001) begin bad++; $display("[TB] FAIL axierr_ready got=%b want=0001", REQ_READY); end
    step();
    REQ_VALID = '0;
    total++; if (OP_TYPE !== 1'b1 || BURST_LEN !== 9'd256 || INIT_AXI_TXN !== 1'b1) begin
      bad++; $display("[TB] FAIL axierr_launch got=%b/%0d/%b want=1/256/1", OP_TYPE, BURST_LEN, INIT_AXI_TXN);
    end
    AXI_TXN_DONE = 1'b1;
    AXI_ERROR    = 1'b1;
    step();
    total++; if (RSP_VALID !== 4'b0000 || BUSY !== 1'b1) begin bad++; $display("[TB] FAIL stale_done got=%b/%b want=0000/1", RSP_VALID, BUSY); end
    step();
    AXI_TXN_DONE = 1'b0;
    AXI_ERROR    = 1'b0;
    total++; if (RSP_VALID !== 4'b0001 || RSP_ERROR !== 1'b1 || BASE_ADDR !== 32'hDEAD_BEEC) begin
      bad++; $display("[TB] FAIL axierr_rsp got=%b/%b/%h want=0001/1/deadbeec", RSP_VALID, RSP_ERROR, BASE_ADDR);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    int stray;
    stray = 0;
    set_req(1, 1'b1, 32'h5000, 9'd4);
    step();
    REQ_VALID = '0;
    step(); step(); step();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    total++; if ({BUSY, INIT_AXI_TXN, RSP_VALID, RSP_ERROR, REQ_READY} !== 11'b0) begin
      bad++; $display("[TB] FAIL rstwait_ctrl got=%b want=0", {BUSY, INIT_AXI_TXN, RSP_VALID, RSP_ERROR, REQ_READY});
    end
    total++; if ({OP_TYPE, BASE_ADDR, BURST_LEN, GRANT_ID} !== 44'h0) begin
      bad++; $display("[TB] FAIL rstwait_fields got=%h want=0", {OP_TYPE, BASE_ADDR, BURST_LEN, GRANT_ID});
    end
    AXI_TXN_DONE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (RSP_VALID !== 4'b0000) stray++;
    end
    AXI_TXN_DONE = 1'b0;
    total++; if (stray != 0) begin bad++; $display("[TB] FAIL rstwait_norsp got=%0d want=0", stray); end
    REQ_VALID = 4'b1111;
    #1;
    total++; if (REQ_READY !== 4'b0001) begin bad++; $display("[TB] FAIL rstwait_prio got=%b want=0001", REQ_READY); end
    REQ_VALID = '0;
    step();
  endtask

  initial begin
    $display("[TB] starting axi_txn_scheduler bench");
    test_reset();
    test_single();
    test_contention();
    test_bad_len();
    test_timeout();
    test_same_cycle();
    test_axi_error();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
